microsequencer: RTL
===================

MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 SHALL have parameter MAX_STATE, default 49, meaning the highest valid microstore state; any computed next state above it is replaced by 0.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of hold-mode cycles before a forced exit.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1; reset is synchronous, active-high.
REQ-005 SHALL have port n_sel, input, 3, next-state mode field driven by the microstore.
REQ-006 SHALL have port cond_sel, input, 2, condition source select: 00 moc, 01 cond_true, 10 constant 1, 11 constant 0.
REQ-007 SHALL have port inv, input, 1, inverts the selected condition.
REQ-008 SHALL have port cr, input, 7, branch/call target state from the microstore.
REQ-009 SHALL have port ir, input, 32, instruction register; only ir[31:26] is used.
REQ-010 SHALL have port moc, input, 1, memory-operation-complete.
REQ-011 SHALL have port cond_true, input, 1, branch condition tester result.
REQ-012 SHALL have port state, output, 7, registered current state that addresses the microstore.
REQ-013 SHALL have port err, output, 1, sticky stack overflow/underflow flag.
REQ-014 SHALL have port timeout, output, 1, one-cycle pulse on a forced hold exit.

Function
REQ-015 SHALL compute c = selected condition XOR inv, combinationally.
REQ-016 SHALL define inc as state+1, with inc > MAX_STATE yielding 0.
REQ-017 SHALL decode ir[31:26] to enc as follows: 000000->6, 001000->17, 001001->17, 100011->30, 101011->31, 000100->34, 000101->35, 000010->45, 000011->46, 001111->49, and any other opcode->5 (illegal state).
REQ-018 SHALL select the next state by n_sel as follows: 000 enc; 001 constant 1 (fetch); 010 inc; 011 c ? cr : inc; 100 c ? cr : enc; 101 call (push inc, go cr); 110 return (pop top); 111 hold.
REQ-019 SHALL, in hold mode, stay in the current state while c=0 and go to inc when c=1.
REQ-020 SHALL count consecutive hold-mode cycles with c=0 in an 8-bit counter, clearing it on any cycle not holding.
REQ-021 SHALL, when the hold counter reaches TIMEOUT with c still 0, move to state 5 on that edge, pulse timeout for one cycle, and clear the counter.
REQ-022 SHALL implement the return stack as a 2-entry LIFO of 7-bit entries with a 2-bit depth count.
REQ-023 SHALL, on a call with the stack full, discard the oldest entry, push the new entry, and set err.
REQ-024 SHALL, on a return with the stack empty, go to state 0, leave the depth at 0, and set err.
REQ-025 SHALL replace any next state above MAX_STATE (including cr and popped values) by 0 before registering it.
REQ-026 SHALL update state exactly one clock after the n_sel/cond inputs are sampled, with no additional latency.
REQ-027 SHALL keep err set until reset; err is never cleared by any other event.

Reset
REQ-028 SHALL, on reset at any clock edge, including mid-hold or mid-call, force state=0, empty the stack, clear the hold counter, and set err=0 and timeout=0.
REQ-029 SHALL give reset priority over every n_sel mode.

Verification
REQ-030 SHALL cover reset, then n_sel=001: state 0 -> 1; then n_sel=000 with ir[31:26]=100011 -> 30; with opcode 111111 -> 5.
REQ-031 SHALL cover n_sel=011, cond_sel=01, cond_true=1, cr=12 -> 12; the same with inv=1 -> state+1.
REQ-032 SHALL cover n_sel=111, cond_sel=00, moc=0 for 10 cycles then 1: state held 10 cycles, then state+1 and timeout stays 0.
REQ-033 SHALL cover holding with moc=0 for 255 cycles: state -> 5, timeout=1 for one cycle.
REQ-034 SHALL cover call from 3 (cr=20), call from 20 (cr=40), call from 40 (cr=44), then 3 returns: states 41, 21, then 0 with err=1.
REQ-035 SHALL cover state 49 with n_sel=010 -> 0, and cr=100 with n_sel=011, c=1 -> 0.

Source files
------------

// File: rtl/microsequencer.sv
// Microsequencer: selects the next microstore state from opcode decode,
// increment, conditional branch, call/return through a 2-deep return stack,
// or a hold mode with a forced exit to the illegal state after a timeout.
module microsequencer #(
    parameter int MAX_STATE = 49,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  n_sel,
    input  logic [1:0]  cond_sel,
    input  logic        inv,
    input  logic [6:0]  cr,
    input  logic [31:0] ir,
    input  logic        moc,
    input  logic        cond_true,
    output logic [6:0]  state,
    output logic        err,
    output logic        timeout
);

    localparam logic [7:0] MAX_S = 8'(MAX_STATE);
    localparam logic [8:0] TO_S  = 9'(TIMEOUT);
    localparam logic [6:0] ILLEGAL_STATE = 7'd5;

    // Only the opcode field of ir matters to sequencing.
    logic ir_unused;
    assign ir_unused = ^ir[25:0];

    logic [6:0] stk0, stk1;       // stk0 is the top of the return stack
    logic [1:0] depth;
    logic [7:0] hold_cnt;

    logic       c_sel, c;
    logic [7:0] inc_full;
    logic [6:0] inc, enc;

    logic [6:0] nxt_raw, nxt_state, nxt_stk0, nxt_stk1;
    logic [1:0] nxt_depth;
    logic [7:0] nxt_cnt;
    logic       nxt_err, nxt_timeout;

    // Any state beyond the microstore maps back to state 0.
    function automatic logic [6:0] clamp(input logic [6:0] s);
        clamp = ({1'b0, s} > MAX_S) ? 7'd0 : s;
    endfunction

    // Condition select, wrapped increment and opcode decode.
    always_comb begin
        case (cond_sel)
            2'b00:   c_sel = moc;
            2'b01:   c_sel = cond_true;
            2'b10:   c_sel = 1'b1;
            default: c_sel = 1'b0;
        endcase
        c = c_sel ^ inv;

        inc_full = {1'b0, state} + 8'd1;
        inc      = (inc_full > MAX_S) ? 7'd0 : inc_full[6:0];

        case (ir[31:26])
            6'b000000: enc = 7'd6;
            6'b001000: enc = 7'd17;
            6'b001001: enc = 7'd17;
            6'b100011: enc = 7'd30;
            6'b101011: enc = 7'd31;
            6'b000100: enc = 7'd34;
            6'b000101: enc = 7'd35;
            6'b000010: enc = 7'd45;
            6'b000011: enc = 7'd46;
            6'b001111: enc = 7'd49;
            default:   enc = ILLEGAL_STATE;
        endcase
    end

    // Next-state, return stack, hold counter and flag updates by n_sel mode.
    always_comb begin
        nxt_raw     = state;
        nxt_stk0    = stk0;
        nxt_stk1    = stk1;
        nxt_depth   = depth;
        nxt_cnt     = 8'd0;
        nxt_err     = err;
        nxt_timeout = 1'b0;
        case (n_sel)
            3'b000: nxt_raw = enc;
            3'b001: nxt_raw = 7'd1;
            3'b010: nxt_raw = inc;
            3'b011: nxt_raw = c ? cr : inc;
            3'b100: nxt_raw = c ? cr : enc;
            3'b101: begin
                // Push shifts the stack; when full the oldest entry falls off.
                nxt_raw  = cr;
                nxt_stk1 = stk0;
                nxt_stk0 = inc;
                if (depth == 2'd2) nxt_err = 1'b1;
                else               nxt_depth = depth + 2'd1;
            end
            3'b110: begin
                if (depth == 2'd0) begin
                    nxt_raw = 7'd0;
                    nxt_err = 1'b1;
                end else begin
                    nxt_raw   = stk0;
                    nxt_stk0  = stk1;
                    nxt_depth = depth - 2'd1;
                end
            end
            default: begin
                if (c) begin
                    nxt_raw = inc;
                end else if ({1'b0, hold_cnt} + 9'd1 == TO_S) begin
                    nxt_raw     = ILLEGAL_STATE;
                    nxt_timeout = 1'b1;
                end else begin
                    nxt_cnt = hold_cnt + 8'd1;
                end
            end
        endcase
        nxt_state = clamp(nxt_raw);
    end

    // State register; reset overrides every mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= 7'd0;
            stk0     <= 7'd0;
            stk1     <= 7'd0;
            depth    <= 2'd0;
            hold_cnt <= 8'd0;
            err      <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= nxt_state;
            stk0     <= nxt_stk0;
            stk1     <= nxt_stk1;
            depth    <= nxt_depth;
            hold_cnt <= nxt_cnt;
            err      <= nxt_err;
            timeout  <= nxt_timeout;
        end
    end

endmodule
